ctrl_pipeline: RTL and testbench

Carries the 11-bit main-control word from ID through the EX, MEM and WB pipeline stages of the MIPS core, with per-stage valid bits and destination-register tags. Owns hazard handling: load-use stall, branch/jump flush, illegal-opcode exception capture, and whole-pipe freeze on data-memory wait. Sits between the main control decoder (ID) and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_pipeline_hazard.sv | 61 ++++++
 rtl/ctrl_pipeline.sv | 138 +++++++++++++
 tb/tb_ctrl_pipeline.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared widths, control-word field positions and stage record types for the control pipeline.
// Pure definitions: no latency, no flow control.
package ctrl_pkg;

    localparam int CTRL_W = 11;
    localparam int REG_W  = 5;

    localparam int CTRL_JUMP      = 10;
    localparam int CTRL_BRANCH    = 9;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_ALUOP_MSB = 5;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ILLEGAL   = 3;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_REGDST    = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  wreg;
    } stage_t;

    // WB only ever needs the two write-back controls, so the rest of the word is not carried.
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] wreg;
    } wb_stage_t;

    typedef enum logic {
        EXC_IDLE    = 1'b0,
        EXC_PENDING = 1'b1
    } exc_state_t;

    localparam stage_t    STAGE_BUBBLE = '{valid: 1'b0, ctrl: CTRL_BUBBLE, wreg: '0};
    localparam wb_stage_t WB_BUBBLE    = '{valid: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, wreg: '0};

    function automatic logic [REG_W-1:0] dest_reg(input logic [CTRL_W-1:0] ctrl,
                                                  input logic [REG_W-1:0]  rt,
                                                  input logic [REG_W-1:0]  rd);
        return ctrl[CTRL_REGDST] ? rd : rt;
    endfunction

    function automatic logic rt_used(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGDST] | ctrl[CTRL_MEMWRITE] | ctrl[CTRL_BRANCH];
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard.sv
// Combinational hazard detection and prioritisation: freeze > exception > redirect > load-use.
// Zero latency; a low mem_ready freezes everything and suppresses all other actions.
module ctrl_pipeline_hazard
    import ctrl_pkg::*;
(
    input  logic             i_ex_valid,
    input  logic             i_ex_jump,
    input  logic             i_ex_branch,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_illegal,
    input  logic [REG_W-1:0] i_ex_wreg,
    input  logic             i_id_valid,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_ready,
    input  logic             i_exc_pending,
    output logic             o_freeze,
    output logic             o_exc_fire,
    output logic             o_ex_bubble,
    output logic             o_mem_bubble,
    output logic             o_stall_if_id,
    output logic             o_flush_if_id
);

    logic w_load_use;
    logic w_redirect;
    logic w_exception;

    assign w_load_use = i_ex_valid && i_ex_mem_read && (i_ex_wreg != '0) && i_id_valid &&
                        ((i_ex_wreg == i_id_rs) || (i_id_rt_used && (i_ex_wreg == i_id_rt)));
    assign w_redirect  = i_ex_valid && (i_ex_jump || (i_ex_branch && i_ex_branch_taken));
    assign w_exception = i_ex_valid && i_ex_illegal;

    always_comb begin
        o_freeze      = 1'b0;
        o_exc_fire    = 1'b0;
        o_ex_bubble   = 1'b0;
        o_mem_bubble  = 1'b0;
        o_stall_if_id = 1'b0;
        o_flush_if_id = 1'b0;
        if (!i_mem_ready) begin
            o_freeze      = 1'b1;
            o_stall_if_id = 1'b1;
        end else if (w_exception) begin
            o_exc_fire    = 1'b1;
            o_mem_bubble  = 1'b1;
            o_ex_bubble   = 1'b1;
            o_flush_if_id = 1'b1;
        end else if (w_redirect || i_exc_pending) begin
            // A pending exception squashes every younger instruction until it is acknowledged.
            o_ex_bubble   = 1'b1;
            o_flush_if_id = 1'b1;
        end else if (w_load_use) begin
            o_ex_bubble   = 1'b1;
            o_stall_if_id = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the ID control word through EX/MEM/WB with valid bits and destination tags; 1/2/3 edges to ex_/mem_/wb_.
// No handshake: mem_ready low freezes every stage and the exception state; hazards stall or flush IF/ID.
module ctrl_pipeline
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic [REG_W-1:0]  i_id_rs,
    input  logic [REG_W-1:0]  i_id_rt,
    input  logic [REG_W-1:0]  i_id_rd,
    input  logic              i_ex_branch_taken,
    input  logic              i_mem_ready,
    input  logic              i_exc_ack,
    output logic              o_ex_valid,
    output logic              o_mem_valid,
    output logic              o_wb_valid,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [CTRL_W-1:0] o_mem_ctrl,
    output logic [REG_W-1:0]  o_ex_wreg,
    output logic [REG_W-1:0]  o_mem_wreg,
    output logic [REG_W-1:0]  o_wb_wreg,
    output logic              o_wb_reg_write,
    output logic              o_wb_mem_to_reg,
    output logic              o_stall_if_id,
    output logic              o_flush_if_id,
    output logic              o_exc_pending
);

    stage_t     r_ex;
    stage_t     r_mem;
    wb_stage_t  r_wb;
    exc_state_t r_exc_state;

    stage_t     w_ex_next;
    stage_t     w_mem_next;
    wb_stage_t  w_wb_next;
    exc_state_t w_exc_state_next;

    logic w_freeze;
    logic w_exc_fire;
    logic w_ex_bubble;
    logic w_mem_bubble;
    logic w_stall;
    logic w_flush;
    logic w_exc_pending;

    assign w_exc_pending = (r_exc_state == EXC_PENDING);

    ctrl_pipeline_hazard u_hazard (
        .i_ex_valid        (r_ex.valid),
        .i_ex_jump         (r_ex.ctrl[CTRL_JUMP]),
        .i_ex_branch       (r_ex.ctrl[CTRL_BRANCH]),
        .i_ex_mem_read     (r_ex.ctrl[CTRL_MEMREAD]),
        .i_ex_illegal      (r_ex.ctrl[CTRL_ILLEGAL]),
        .i_ex_wreg         (r_ex.wreg),
        .i_id_valid        (i_id_valid),
        .i_id_rt_used      (rt_used(i_id_ctrl)),
        .i_id_rs           (i_id_rs),
        .i_id_rt           (i_id_rt),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_mem_ready       (i_mem_ready),
        .i_exc_pending     (w_exc_pending),
        .o_freeze          (w_freeze),
        .o_exc_fire        (w_exc_fire),
        .o_ex_bubble       (w_ex_bubble),
        .o_mem_bubble      (w_mem_bubble),
        .o_stall_if_id     (w_stall),
        .o_flush_if_id     (w_flush)
    );

    // An invalid ID slot enters EX as a full bubble so stale control bits never linger downstream.
    always_comb begin
        w_ex_next = STAGE_BUBBLE;
        if (i_id_valid && !w_ex_bubble) begin
            w_ex_next.valid = 1'b1;
            w_ex_next.ctrl  = i_id_ctrl;
            w_ex_next.wreg  = dest_reg(i_id_ctrl, i_id_rt, i_id_rd);
        end
    end

    always_comb begin
        w_mem_next = w_mem_bubble ? STAGE_BUBBLE : r_ex;
        w_wb_next  = WB_BUBBLE;
        w_wb_next.valid      = r_mem.valid;
        w_wb_next.reg_write  = r_mem.ctrl[CTRL_REGWRITE];
        w_wb_next.mem_to_reg = r_mem.ctrl[CTRL_MEMTOREG];
        w_wb_next.wreg       = r_mem.wreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= STAGE_BUBBLE;
            r_mem <= STAGE_BUBBLE;
            r_wb  <= WB_BUBBLE;
        end else if (!w_freeze) begin
            r_ex  <= w_ex_next;
            r_mem <= w_mem_next;
            r_wb  <= w_wb_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_state <= EXC_IDLE;
        end else begin
            r_exc_state <= w_exc_state_next;
        end
    end

    // A new fault beats a simultaneous acknowledge; nothing moves while frozen.
    always_comb begin
        w_exc_state_next = r_exc_state;
        if (!w_freeze) begin
            case (r_exc_state)
                EXC_IDLE:    if (w_exc_fire) w_exc_state_next = EXC_PENDING;
                EXC_PENDING: if (!w_exc_fire && i_exc_ack) w_exc_state_next = EXC_IDLE;
                default:     w_exc_state_next = EXC_IDLE;
            endcase
        end
    end

    assign o_ex_valid      = r_ex.valid;
    assign o_ex_ctrl       = r_ex.ctrl;
    assign o_ex_wreg       = r_ex.wreg;
    assign o_mem_valid     = r_mem.valid;
    assign o_mem_ctrl      = r_mem.ctrl;
    assign o_mem_wreg      = r_mem.wreg;
    assign o_wb_valid      = r_wb.valid;
    assign o_wb_wreg       = r_wb.wreg;
    assign o_wb_reg_write  = r_wb.valid & r_wb.reg_write;
    assign o_wb_mem_to_reg = r_wb.valid & r_wb.mem_to_reg;
    assign o_exc_pending   = w_exc_pending;
    assign o_stall_if_id   = rst_n & w_stall;
    assign o_flush_if_id   = rst_n & w_flush;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboarded bench: a stage-array reference model predicts every cycle's outputs, a monitor compares them.
module tb_ctrl_pipeline;
    import ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [REG_W-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic              ex_branch_taken = 1'b0;
    logic              mem_ready = 1'b0;
    logic              exc_ack = 1'b0;

    logic              ex_valid, mem_valid, wb_valid;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl;
    logic [REG_W-1:0]  ex_wreg, mem_wreg, wb_wreg;
    logic              wb_reg_write, wb_mem_to_reg, stall_if_id, flush_if_id, exc_pending;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_id_valid        (id_valid),
        .i_id_ctrl         (id_ctrl),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_rd           (id_rd),
        .i_ex_branch_taken (ex_branch_taken),
        .i_mem_ready       (mem_ready),
        .i_exc_ack         (exc_ack),
        .o_ex_valid        (ex_valid),
        .o_mem_valid       (mem_valid),
        .o_wb_valid        (wb_valid),
        .o_ex_ctrl         (ex_ctrl),
        .o_mem_ctrl        (mem_ctrl),
        .o_ex_wreg         (ex_wreg),
        .o_mem_wreg        (mem_wreg),
        .o_wb_wreg         (wb_wreg),
        .o_wb_reg_write    (wb_reg_write),
        .o_wb_mem_to_reg   (wb_mem_to_reg),
        .o_stall_if_id     (stall_if_id),
        .o_flush_if_id     (flush_if_id),
        .o_exc_pending     (exc_pending)
    );

    typedef struct packed {
        stage_t ex;
        stage_t mem;
        stage_t wb;
        logic   rw;
        logic   m2r;
        logic   stall;
        logic   flush;
        logic   pend;
    } exp_t;

    exp_t   exp_q[$];
    int     n_chk = 0;
    int     n_fail = 0;

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, plus the sticky exception flag.
    stage_t pipe[3];
    logic   m_pend;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_pend = 1'b0;
    endfunction

    function automatic logic fault();
        return pipe[0].valid && pipe[0].ctrl[3];
    endfunction

    function automatic logic redirect();
        return pipe[0].valid && (pipe[0].ctrl[10] || (pipe[0].ctrl[9] && ex_branch_taken));
    endfunction

    function automatic logic load_use();
        logic rt_needed;
        rt_needed = id_ctrl[0] | id_ctrl[7] | id_ctrl[9];
        return pipe[0].valid && pipe[0].ctrl[6] && pipe[0].wreg != 0 && id_valid &&
               (pipe[0].wreg == id_rs || (rt_needed && pipe[0].wreg == id_rt));
    endfunction

    // Advance the model by one clock edge using the inputs that were held across it.
    function automatic void model_edge();
        logic f, r, lu, take;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (!mem_ready) return;
        f  = fault();
        r  = redirect();
        lu = load_use();
        take = id_valid && !m_pend && !f && !r && !lu;
        pipe[2] = pipe[1];
        pipe[1] = f ? stage_t'('0) : pipe[0];
        pipe[0] = '0;
        if (take) begin
            pipe[0].valid = 1'b1;
            pipe[0].ctrl  = id_ctrl;
            pipe[0].wreg  = id_ctrl[0] ? id_rd : id_rt;
        end
        m_pend = f | (m_pend & ~exc_ack);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.ex    = pipe[0];
        e.mem   = pipe[1];
        e.wb    = pipe[2];
        e.rw    = pipe[2].valid & pipe[2].ctrl[1];
        e.m2r   = pipe[2].valid & pipe[2].ctrl[8];
        e.pend  = m_pend;
        e.flush = rst_n && mem_ready && (fault() || redirect() || m_pend);
        e.stall = rst_n && !e.flush && (!mem_ready || load_use());
        return e;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [CTRL_W-1:0] c,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] rd, input logic tk, input logic mr,
                       input logic ack);
        @(posedge clk);
        #1;
        model_edge();
        rst_n = r; id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        ex_branch_taken = tk; mem_ready = mr; exc_ack = ack;
        if (!rst_n) model_clear();
        exp_q.push_back(predict());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, '0, '0, '0, 0, 1, 0);
    endtask

    task automatic fill3();
        cyc(1, 1, 11'h003, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(1, 1, 11'h162, 5'd4, 5'd5, 5'd6, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd7, 5'd9, 5'd10, 0, 1, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ex_stage",    {15'd0, ex_valid, ex_ctrl, ex_wreg},   {15'd0, e.ex});
                chk("mem_stage",   {15'd0, mem_valid, mem_ctrl, mem_wreg}, {15'd0, e.mem});
                chk("wb_stage",    {26'd0, wb_valid, wb_wreg},           {26'd0, e.wb.valid, e.wb.wreg});
                chk("wb_controls", {30'd0, wb_reg_write, wb_mem_to_reg}, {30'd0, e.rw, e.m2r});
                chk("stall_if_id", {31'd0, stall_if_id},                 {31'd0, e.stall});
                chk("flush_if_id", {31'd0, flush_if_id},                 {31'd0, e.flush});
                chk("exc_pending", {31'd0, exc_pending},                 {31'd0, e.pend});
            end
        end
    end

    initial begin : driver
        logic [CTRL_W-1:0] rc;
        model_clear();
        // Reset held with memory not ready: stall must still read 0.
        cyc(0, 1, 11'h161, 5'd8, 5'd8, 5'd8, 1, 0, 0);
        cyc(0, 0, '0, '0, '0, '0, 0, 1, 0);
        idle(2);

        // lw $t0 then dependent add: one stall cycle, add retires with reg_write.
        cyc(1, 1, 11'h161, 5'd0, 5'd8, 5'd8, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd8, 5'd9, 5'd10, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd8, 5'd9, 5'd10, 0, 1, 0);
        idle(4);

        // Taken beq in EX flushes the younger ID instruction.
        cyc(1, 1, 11'h210, 5'd1, 5'd2, 5'd0, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd5, 1, 1, 0);
        idle(3);

        // Illegal opcode: dropped, younger work squashed until acknowledged.
        cyc(1, 1, 11'h008, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd5, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd6, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd7, 0, 1, 1);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd11, 0, 1, 0);
        idle(4);

        // Full pipe frozen for three cycles with an ignored ack, then resumes.
        fill3();
        cyc(1, 1, 11'h003, 5'd1, 5'd1, 5'd12, 0, 0, 1);
        cyc(1, 1, 11'h003, 5'd1, 5'd1, 5'd12, 0, 0, 1);
        cyc(1, 1, 11'h003, 5'd1, 5'd1, 5'd12, 0, 0, 0);
        idle(4);

        // Load-use and taken branch together: flush only.
        cyc(1, 1, 11'h240, 5'd1, 5'd8, 5'd0, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd8, 5'd2, 5'd3, 1, 1, 0);
        idle(3);

        // Fault and ack in the same cycle: pending stays set.
        cyc(1, 1, 11'h008, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd3, 5'd4, 5'd5, 0, 1, 1);
        cyc(1, 0, '0, '0, '0, '0, 0, 1, 1);
        idle(4);

        // Reset mid-stream with every stage full, also asserted while an exception is pending.
        fill3();
        cyc(0, 1, 11'h023, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(0, 1, 11'h023, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        idle(4);
        cyc(1, 1, 11'h008, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(1, 1, 11'h023, 5'd1, 5'd2, 5'd3, 0, 1, 0);
        cyc(0, 0, '0, '0, '0, '0, 0, 1, 0);
        idle(4);

        // Randomised traffic over small register indices to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            rc = CTRL_W'($urandom);
            if ($urandom_range(0, 15) != 0) rc[3] = 1'b0;
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, rc,
                REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                REG_W'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) == 0);
        end
        idle(4);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
